// File: rtl/frame_load_sequencer.sv
// Frame admission / drain / run sequencer in front of the 512->32 converter.
// Owns the shared data-memory write port and the core start/abort handshake.
module frame_load_sequencer #(
  parameter int unsigned MAX_BEATS   = 32,
  parameter int unsigned DRAIN_WORDS = 512,
  parameter int unsigned RUN_TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         snk_sop,
  input  logic         snk_eop,
  input  logic         snk_valid,
  input  logic [511:0] snk_din,
  output logic         snk_ready,
  output logic         conv_sop,
  output logic         conv_eop,
  output logic         conv_valid,
  output logic [511:0] conv_din,
  input  logic [31:0]  conv_addr,
  input  logic [31:0]  conv_din32,
  input  logic         conv_we,
  input  logic [31:0]  core_addr,
  input  logic [31:0]  core_din,
  input  logic         core_we,
  output logic         core_start,
  input  logic         core_done,
  output logic         core_abort,
  output logic [31:0]  dmem_addr,
  output logic [31:0]  dmem_din,
  output logic         dmem_we,
  output logic         busy,
  output logic         err_overflow,
  output logic         err_drop,
  output logic         err_timeout,
  input  logic         err_clr,
  output logic [15:0]  frame_count
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int WW = (DRAIN_WORDS > 1) ? $clog2(DRAIN_WORDS) : 1;
  localparam int TW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_FLUSH, S_DRAIN, S_START, S_RUN
  } state_t;

  state_t         state_q;
  logic [BW-1:0]  beat_cnt_q;
  logic [WW-1:0]  word_cnt_q;
  logic [TW-1:0]  timer_q;
  logic [15:0]    frame_cnt_q;
  logic           cv_sop_q, cv_eop_q, cv_valid_q;
  logic [511:0]   cv_din_q;
  logic           ovf_q, drop_q, tmo_q;

  logic beat_full, word_last, to_hit;
  logic fwd, set_ovf, set_drop;

  assign beat_full = beat_cnt_q == BW'(MAX_BEATS);
  assign word_last = word_cnt_q == WW'(DRAIN_WORDS - 1);

  // done in the same cycle as expiry wins, so abort is masked by it
  assign to_hit = (RUN_TIMEOUT != 0) && (state_q == S_RUN)
               && (timer_q == TW'(RUN_TIMEOUT - 1)) && !core_done;

  assign snk_ready = (state_q == S_IDLE) || (state_q == S_RECV)
                  || (state_q == S_FLUSH);

  assign fwd = snk_valid && (
      ((state_q == S_IDLE) && snk_sop)
    || ((state_q == S_RECV) && (snk_sop || snk_eop || !beat_full)));

  assign set_ovf = (state_q == S_RECV) && snk_valid
                && !snk_sop && !snk_eop && beat_full;

  assign set_drop = snk_valid && !snk_ready;

  assign conv_sop     = cv_sop_q;
  assign conv_eop     = cv_eop_q;
  assign conv_valid   = cv_valid_q;
  assign conv_din     = cv_din_q;
  assign core_start   = state_q == S_START;
  assign core_abort   = to_hit;
  assign busy         = state_q != S_IDLE;
  assign err_overflow = ovf_q;
  assign err_drop     = drop_q;
  assign err_timeout  = tmo_q;
  assign frame_count  = frame_cnt_q;

  always_comb begin
    dmem_addr = '0;
    dmem_din  = '0;
    dmem_we   = 1'b0;
    unique case (1'b1)
      (state_q == S_DRAIN): begin
        dmem_addr = conv_addr;
        dmem_din  = conv_din32;
        dmem_we   = conv_we;
      end
      (state_q == S_RUN): begin
        dmem_addr = core_addr;
        dmem_din  = core_din;
        dmem_we   = core_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      word_cnt_q  <= '0;
      timer_q     <= '0;
      frame_cnt_q <= '0;
      cv_sop_q    <= 1'b0;
      cv_eop_q    <= 1'b0;
      cv_valid_q  <= 1'b0;
      cv_din_q    <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      cv_valid_q <= fwd;
      cv_sop_q   <= fwd && snk_sop;
      cv_eop_q   <= fwd && snk_eop;
      if (fwd) cv_din_q <= snk_din;

      ovf_q  <= set_ovf  || (ovf_q  && !err_clr);
      drop_q <= set_drop || (drop_q && !err_clr);
      tmo_q  <= to_hit   || (tmo_q  && !err_clr);

      unique case (state_q)
        S_IDLE: begin
          if (snk_valid && snk_sop) begin
            beat_cnt_q <= BW'(1);
            state_q    <= snk_eop ? S_DRAIN : S_RECV;
          end
        end
        S_RECV: begin
          if (snk_valid) begin
            if (snk_sop) begin
              beat_cnt_q <= BW'(1);
              if (snk_eop) state_q <= S_DRAIN;
            end else if (snk_eop) begin
              state_q <= S_DRAIN;
            end else if (beat_full) begin
              state_q <= S_FLUSH;
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (snk_valid && snk_eop) state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (conv_we) begin
            if (word_last) begin
              word_cnt_q <= '0;
              state_q    <= S_START;
            end else begin
              word_cnt_q <= word_cnt_q + WW'(1);
            end
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          timer_q <= timer_q + TW'(1);
          if (core_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= S_IDLE;
          end else if (to_hit) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_load_sequencer.sv
// Directed bench for frame_load_sequencer: load, drain, run, overflow,
// watchdog, drop and mid-drain reset scenarios.
module tb_frame_load_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         snk_sop, snk_eop, snk_valid;
  logic [511:0] snk_din;
  logic         snk_ready;
  logic         conv_sop, conv_eop, conv_valid;
  logic [511:0] conv_din;
  logic [31:0]  conv_addr, conv_din32;
  logic         conv_we;
  logic [31:0]  core_addr, core_din;
  logic         core_we;
  logic         core_start, core_done, core_abort;
  logic [31:0]  dmem_addr, dmem_din;
  logic         dmem_we, busy;
  logic         err_overflow, err_drop, err_timeout, err_clr;
  logic [15:0]  frame_count;

  always #5 clk = ~clk;

  frame_load_sequencer #(
    .MAX_BEATS(32), .DRAIN_WORDS(512), .RUN_TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset),
    .snk_sop(snk_sop), .snk_eop(snk_eop),
    .snk_valid(snk_valid), .snk_din(snk_din),
    .snk_ready(snk_ready),
    .conv_sop(conv_sop), .conv_eop(conv_eop),
    .conv_valid(conv_valid), .conv_din(conv_din),
    .conv_addr(conv_addr), .conv_din32(conv_din32),
    .conv_we(conv_we),
    .core_addr(core_addr), .core_din(core_din),
    .core_we(core_we),
    .core_start(core_start), .core_done(core_done),
    .core_abort(core_abort),
    .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_we(dmem_we), .busy(busy),
    .err_overflow(err_overflow), .err_drop(err_drop),
    .err_timeout(err_timeout), .err_clr(err_clr),
    .frame_count(frame_count)
  );

  int ntot = 0;
  int nbad = 0;
  int cyc = 0;
  int n_cv = 0, n_we = 0, n_start = 0, n_abort = 0;
  int n_badwr = 0;
  int start_t = 0, abort_t = 0;
  logic [511:0] last_din = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (conv_valid) begin
      n_cv++;
      last_din = conv_din;
    end
    if (dmem_we) begin
      n_we++;
      if (dmem_addr[31:16] == 16'hDEAD) n_badwr++;
    end
    if (core_start) begin
      n_start++;
      start_t = cyc;
    end
    if (core_abort) begin
      n_abort++;
      abort_t = cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic s, input logic e,
                      input logic [31:0] d);
    snk_valid = 1'b1;
    snk_sop   = s;
    snk_eop   = e;
    snk_din   = {480'd0, d};
    sync();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic drain(input int n, input logic noise);
    for (int i = 0; i < n; i++) begin
      conv_we    = 1'b1;
      conv_addr  = 32'(i * 4);
      conv_din32 = 32'(32'h1000 + i);
      if (noise) begin
        core_we   = 1'b1;
        core_addr = 32'hDEAD_0000 | 32'(i);
        snk_valid = 1'b1;
      end
      sync();
    end
    conv_we   = 1'b0;
    core_we   = 1'b0;
    snk_valid = 1'b0;
  endtask

  task automatic run_done(input int k);
    repeat (k) sync();
    core_we   = 1'b1;
    core_addr = 32'h100;
    core_din  = 32'h55;
    @(negedge clk);
    chk("run_wr", {dmem_we, dmem_addr, dmem_din}, {1'b1, 32'h100, 32'h55});
    sync();
    core_we   = 1'b0;
    core_done = 1'b1;
    sync();
    core_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", ntot, nbad);
    $fatal(1, "timeout");
  end

  initial begin
    int b_cv, b_we, b_st, b_ab;
    reset = 1'b0;
    {snk_sop, snk_eop, snk_valid} = '0;
    snk_din = '0;
    conv_addr = '0; conv_din32 = '0; conv_we = 1'b0;
    core_addr = '0; core_din = '0; core_we = 1'b0;
    core_done = 1'b0; err_clr = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", snk_ready, 1);
    chk("rst_outs", {busy, conv_valid, core_start, core_abort, dmem_we},
        0);
    chk("rst_err", {err_overflow, err_drop, err_timeout}, 0);
    chk("rst_fc", frame_count, 0);
    sync();
    reset = 1'b1;
    sync();

    // full 32-beat frame
    b_cv = n_cv; b_we = n_we; b_st = n_start;
    for (int i = 0; i < 32; i++) beat(i == 0, i == 31, 32'(i));
    @(negedge clk);
    chk("t1_ready", snk_ready, 0);
    sync();
    drain(512, 1'b0);
    @(negedge clk);
    chk("t1_start", core_start, 1);
    sync();
    run_done(3);
    @(negedge clk);
    chk("t1_cv", n_cv - b_cv, 32);
    chk("t1_we", n_we - b_we, 513);
    chk("t1_st", n_start - b_st, 1);
    chk("t1_last", last_din[63:0], 31);
    chk("t1_fc", frame_count, 1);
    chk("t1_idle", busy, 0);
    sync();

    // single beat frame
    beat(1'b1, 1'b1, 32'hABC);
    drain(511, 1'b0);
    @(negedge clk);
    chk("t2_nostart", core_start, 0);
    chk("t2_busy", busy, 1);
    sync();
    drain(1, 1'b0);
    @(negedge clk);
    chk("t2_start", core_start, 1);
    chk("t2_din", last_din[63:0], 64'hABC);
    sync();
    run_done(2);
    @(negedge clk);
    chk("t2_fc", frame_count, 2);
    sync();

    // stray beat, then overflow
    b_cv = n_cv; b_st = n_start;
    beat(1'b0, 1'b0, 32'd5);
    @(negedge clk);
    chk("t3_stray", {busy, err_drop}, 0);
    sync();
    beat(1'b1, 1'b0, 32'd0);
    for (int i = 1; i <= 32; i++) beat(1'b0, 1'b0, 32'(i));
    beat(1'b0, 1'b1, 32'd99);
    repeat (3) sync();
    @(negedge clk);
    chk("t3_cv", n_cv - b_cv, 32);
    chk("t3_last", last_din[63:0], 31);
    chk("t3_ovf", err_overflow, 1);
    chk("t3_st", n_start - b_st, 0);
    chk("t3_idle", busy, 0);
    sync();
    err_clr = 1'b1;
    sync();
    err_clr = 1'b0;
    @(negedge clk);
    chk("t3_clr", err_overflow, 0);
    sync();

    // watchdog
    b_ab = n_abort;
    beat(1'b1, 1'b1, 32'd7);
    drain(512, 1'b0);
    for (int i = 0; i < 200 && n_abort == b_ab; i++) @(negedge clk);
    chk("t4_seen", n_abort - b_ab, 1);
    chk("t4_lat", abort_t - start_t, 100);
    sync();
    repeat (3) sync();
    @(negedge clk);
    chk("t4_once", n_abort - b_ab, 1);
    chk("t4_tmo", err_timeout, 1);
    chk("t4_idle", busy, 0);
    chk("t4_fc", frame_count, 2);
    sync();

    // drops and stray core writes during drain
    beat(1'b1, 1'b1, 32'd8);
    b_cv = n_cv; b_we = n_we;
    drain(512, 1'b1);
    @(negedge clk);
    chk("t5_start", core_start, 1);
    chk("t5_drop", err_drop, 1);
    chk("t5_badwr", n_badwr, 0);
    chk("t5_we", n_we - b_we, 512);
    chk("t5_cv", n_cv - b_cv, 1);
    sync();
    run_done(1);
    @(negedge clk);
    chk("t5_fc", frame_count, 3);
    sync();
    err_clr = 1'b1;
    sync();
    err_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr", {err_drop, err_timeout}, 0);
    sync();

    // reset mid-drain
    beat(1'b1, 1'b1, 32'd9);
    drain(100, 1'b0);
    reset = 1'b0;
    #1;
    chk("t6_ready", snk_ready, 1);
    chk("t6_outs", {busy, conv_valid, core_start, dmem_we}, 0);
    chk("t6_fc", frame_count, 0);
    sync();
    reset = 1'b1;
    sync();
    b_st = n_start;
    beat(1'b1, 1'b1, 32'd10);
    drain(512, 1'b0);
    @(negedge clk);
    chk("t6_start", core_start, 1);
    sync();
    run_done(1);
    @(negedge clk);
    chk("t6_st", n_start - b_st, 1);
    chk("t6_fc2", frame_count, 1);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
